// File: rtl/bus_request_ctrl_pkg.sv
// Shared definitions for the bus request controller: channel state encoding and master count.
package bus_request_ctrl_pkg;

  localparam int NUM_MASTERS = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2,
    ST_HOLD = 2'd3
  } ch_state_t;

endpackage

// File: rtl/bus_req_channel.sv
// One master's request FSM: holds request until the burst's last granted beat, then a hold-off gap.
// Start->request 1 cycle, last beat->request low 1 cycle; a lost grant re-requests, a grantless wait times out.
module bus_req_channel
  import bus_request_ctrl_pkg::*;
#(
  parameter int LEN_W       = 4,
  parameter int HOLDOFF_CYC = 2,
  parameter int TIMEOUT_CYC = 64,
  parameter int TO_W        = 7
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             grant,
  input  logic             beat_ack,
  output logic             request,
  output logic             busy,
  output logic             done,
  output logic             timeout
);

  localparam int HOLD_W = (HOLDOFF_CYC > 1) ? $clog2(HOLDOFF_CYC) : 1;

  ch_state_t         state;
  logic [LEN_W-1:0]  rem;
  logic [TO_W-1:0]   wait_cnt;
  logic [HOLD_W-1:0] hold_cnt;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state    <= ST_IDLE;
      rem      <= '0;
      wait_cnt <= '0;
      hold_cnt <= '0;
      request  <= 1'b0;
      done     <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      done    <= 1'b0;
      timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (len == '0) begin
              done <= 1'b1;
            end else begin
              rem      <= len;
              wait_cnt <= '0;
              request  <= 1'b1;
              state    <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (grant) begin
            state <= ST_XFER;
          end else if (wait_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
            request <= 1'b0;
            timeout <= 1'b1;
            state   <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + TO_W'(1);
          end
        end
        ST_XFER: begin
          if (grant && beat_ack) begin
            if (rem == LEN_W'(1)) begin
              request  <= 1'b0;
              done     <= 1'b1;
              hold_cnt <= '0;
              state    <= ST_HOLD;
            end else begin
              rem <= rem - LEN_W'(1);
            end
          end else if (!grant) begin
            // Preempted mid-burst: re-request for the remaining beats.
            wait_cnt <= '0;
            state    <= ST_REQ;
          end
        end
        ST_HOLD: begin
          // The arbiter's grant lags our request drop by one cycle; that stray grant lands here and is ignored.
          if (hold_cnt == HOLD_W'(HOLDOFF_CYC - 1)) begin
            state <= ST_IDLE;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: rtl/bus_request_ctrl.sv
// Turns per-master start pulses into the held request vector for the 3-master fixed-priority arbiter.
// Request rises 1 cycle after start and drops 1 cycle after the last acked beat; grant and beat_ack are the only backpressure.
module bus_request_ctrl
  import bus_request_ctrl_pkg::*;
#(
  parameter int LEN_W       = 4,
  parameter int HOLDOFF_CYC = 2,
  parameter int TIMEOUT_CYC = 64,
  parameter int TO_W        = 7
) (
  input  logic                     Clock,
  input  logic                     Resetn,
  input  logic [1:3]               i_start,
  input  logic [3*LEN_W-1:0]       i_len,
  input  logic [1:3]               i_grant,
  input  logic                     i_beat_ack,
  output logic [3:0]               o_request,
  output logic [1:3]               o_busy,
  output logic [1:3]               o_done,
  output logic [1:3]               o_timeout
);

  assign o_request[0] = 1'b0;

  for (genvar k = 1; k <= NUM_MASTERS; k++) begin : g_ch
    bus_req_channel #(
      .LEN_W      (LEN_W),
      .HOLDOFF_CYC(HOLDOFF_CYC),
      .TIMEOUT_CYC(TIMEOUT_CYC),
      .TO_W       (TO_W)
    ) u_ch (
      .Clock   (Clock),
      .Resetn  (Resetn),
      .start   (i_start[k]),
      .len     (i_len[k*LEN_W-1 -: LEN_W]),
      .grant   (i_grant[k]),
      .beat_ack(i_beat_ack),
      .request (o_request[k]),
      .busy    (o_busy[k]),
      .done    (o_done[k]),
      .timeout (o_timeout[k])
    );
  end

endmodule

// File: tb/tb_bus_request_ctrl.sv
// Bench for bus_request_ctrl: directed scenarios plus randomized traffic against a burst-level reference model.
module tb_bus_request_ctrl;

  localparam int LEN_W       = 4;
  localparam int HOLDOFF_CYC = 2;
  localparam int TIMEOUT_CYC = 64;
  localparam int TO_W        = 7;

  logic               Clock = 1'b0;
  logic               Resetn;
  logic [1:3]         i_start;
  logic [3*LEN_W-1:0] i_len;
  logic [1:3]         i_grant;
  logic               i_beat_ack;
  logic [3:0]         o_request;
  logic [1:3]         o_busy;
  logic [1:3]         o_done;
  logic [1:3]         o_timeout;

  bus_request_ctrl #(
    .LEN_W      (LEN_W),
    .HOLDOFF_CYC(HOLDOFF_CYC),
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .TO_W       (TO_W)
  ) dut (
    .Clock     (Clock),
    .Resetn    (Resetn),
    .i_start   (i_start),
    .i_len     (i_len),
    .i_grant   (i_grant),
    .i_beat_ack(i_beat_ack),
    .o_request (o_request),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_timeout (o_timeout)
  );

  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;
  logic arb_on;

  logic [12:0] dut_vec;
  assign dut_vec = {o_request, o_busy, o_done, o_timeout};

  always @(posedge Clock)
    assert ($onehot0(i_grant)) else $error("FAIL grant_onehot grant=%b", i_grant);

  // Burst-level model: beats still owed, whether the grant is held, cycles waited, gap cycles left.
  int m_left [1:3];
  int m_wait [1:3];
  int m_gap  [1:3];
  bit m_gnt  [1:3];
  bit m_done [1:3];
  bit m_to   [1:3];

  function automatic void model_reset();
    for (int k = 1; k <= 3; k++) begin
      m_left[k] = 0; m_wait[k] = 0; m_gap[k] = 0;
      m_gnt[k] = 0; m_done[k] = 0; m_to[k] = 0;
    end
  endfunction

  function automatic void model_update();
    for (int k = 1; k <= 3; k++) begin
      int len;
      len = int'(i_len[k*LEN_W-1 -: LEN_W]);
      m_done[k] = 0;
      m_to[k]   = 0;
      if (m_gap[k] > 0) begin
        m_gap[k]--;
      end else if (m_left[k] == 0) begin
        if (i_start[k]) begin
          if (len == 0) m_done[k] = 1;
          else begin m_left[k] = len; m_gnt[k] = 0; m_wait[k] = 0; end
        end
      end else if (!m_gnt[k]) begin
        if (i_grant[k]) m_gnt[k] = 1;
        else if (m_wait[k] == TIMEOUT_CYC - 1) begin m_left[k] = 0; m_to[k] = 1; end
        else m_wait[k]++;
      end else if (i_grant[k] && i_beat_ack) begin
        m_left[k]--;
        if (m_left[k] == 0) begin m_done[k] = 1; m_gap[k] = HOLDOFF_CYC; end
      end else if (!i_grant[k]) begin
        m_gnt[k]  = 0;
        m_wait[k] = 0;
      end
    end
  endfunction

  function automatic logic [12:0] exp_vec();
    logic [3:0] r;
    logic [1:3] b, d, t;
    r = '0;
    for (int k = 1; k <= 3; k++) begin
      r[k] = (m_left[k] != 0);
      b[k] = (m_left[k] != 0) || (m_gap[k] != 0);
      d[k] = m_done[k];
      t[k] = m_to[k];
    end
    return {r, b, d, t};
  endfunction

  task automatic set_len(input int k, input logic [LEN_W-1:0] v);
    i_len[k*LEN_W-1 -: LEN_W] = v;
  endtask

  // One clock: model consumes the current inputs, registered fixed-priority arbiter follows the request vector.
  task automatic tick();
    logic [1:3] g;
    g = '0;
    if (o_request[1]) g[1] = 1'b1;
    else if (o_request[2]) g[2] = 1'b1;
    else if (o_request[3]) g[3] = 1'b1;
    model_update();
    @(posedge Clock);
    #1;
    if (arb_on) i_grant = g;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge Clock);
    #1;
    checks++;
    if (dut_vec !== 13'd0) begin errors++; $display("FAIL reset_init got %b want %b", dut_vec, 13'd0); end
    Resetn = 1'b1;
    i_start[1] = 1'b1; set_len(1, 4'd5);
    tick();
    i_start = '0;
    tick();
    checks++;
    if (dut_vec !== exp_vec()) begin errors++; $display("FAIL reset_pre got %b want %b", dut_vec, exp_vec()); end
    #2 Resetn = 1'b0;
    #1;
    checks++;
    if (dut_vec !== 13'd0) begin errors++; $display("FAIL reset_async got %b want %b", dut_vec, 13'd0); end
    model_reset();
    @(posedge Clock);
    #1 Resetn = 1'b1;
    repeat (4) begin
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL reset_release got %b want %b", dut_vec, exp_vec()); end
    end
  endtask

  task automatic test_single_burst();
    int done_at, busy_low_at, n_done;
    done_at = 0; busy_low_at = 0; n_done = 0;
    arb_on = 1'b1; i_beat_ack = 1'b1;
    i_start[2] = 1'b1; set_len(2, 4'd3);
    for (int t = 1; t <= 12; t++) begin
      tick();
      i_start = '0;
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL single_vec t=%0d got %b want %b", t, dut_vec, exp_vec()); end
      if (o_done[2]) begin n_done++; if (done_at == 0) done_at = t; end
      if (!o_busy[2] && busy_low_at == 0) busy_low_at = t;
    end
    checks++;
    if (done_at !== 6 || n_done !== 1) begin errors++; $display("FAIL single_done at=%0d n=%0d want at=6 n=1", done_at, n_done); end
    checks++;
    if (busy_low_at !== 6 + HOLDOFF_CYC) begin errors++; $display("FAIL single_busy_low got %0d want %0d", busy_low_at, 6 + HOLDOFF_CYC); end
  endtask

  task automatic test_zero_len();
    arb_on = 1'b0; i_grant = '0;
    i_start[1] = 1'b1; set_len(1, 4'd0);
    tick();
    i_start = '0;
    checks++;
    if ({o_request, o_busy, o_done} !== {4'b0000, 3'b000, 3'b100}) begin
      errors++; $display("FAIL zero_done got req=%b busy=%b done=%b want 0000 000 100", o_request, o_busy, o_done);
    end
    tick();
    checks++;
    if (dut_vec !== 13'd0 || dut_vec !== exp_vec()) begin errors++; $display("FAIL zero_after got %b want %b", dut_vec, 13'd0); end
  endtask

  task automatic test_timeout();
    int hi, to_at, n_to;
    hi = 0; to_at = 0; n_to = 0;
    arb_on = 1'b0; i_grant = '0;
    i_start[3] = 1'b1; set_len(3, 4'd1);
    for (int t = 1; t <= 70; t++) begin
      tick();
      i_start = '0;
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL timeout_vec t=%0d got %b want %b", t, dut_vec, exp_vec()); end
      if (o_request[3]) hi++;
      if (o_timeout[3]) begin n_to++; if (to_at == 0) to_at = t; end
    end
    checks++;
    if (to_at !== TIMEOUT_CYC + 1 || n_to !== 1) begin
      errors++; $display("FAIL timeout_pulse at=%0d n=%0d want at=%0d n=1", to_at, n_to, TIMEOUT_CYC + 1);
    end
    checks++;
    if (hi !== TIMEOUT_CYC || o_busy[3] !== 1'b0) begin
      errors++; $display("FAIL timeout_req_cycles got %0d busy=%b want %0d busy=0", hi, o_busy[3], TIMEOUT_CYC);
    end
  endtask

  task automatic test_contention();
    int d_at [1:3];
    int want [1:3];
    want[1] = 5; want[2] = 9; want[3] = 13;
    for (int k = 1; k <= 3; k++) begin d_at[k] = 0; set_len(k, 4'd2); end
    arb_on = 1'b1; i_beat_ack = 1'b1;
    i_start = 3'b111;
    for (int t = 1; t <= 20; t++) begin
      tick();
      i_start = '0;
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL contention_vec t=%0d got %b want %b", t, dut_vec, exp_vec()); end
      for (int k = 1; k <= 3; k++) if (o_done[k] && d_at[k] == 0) d_at[k] = t;
    end
    for (int k = 1; k <= 3; k++) begin
      checks++;
      if (d_at[k] !== want[k]) begin errors++; $display("FAIL contention_order m%0d done at %0d want %0d", k, d_at[k], want[k]); end
    end
  endtask

  task automatic test_back_to_back();
    int low_run, gap, n_done;
    bit seen_hi;
    low_run = 0; gap = -1; n_done = 0; seen_hi = 0;
    arb_on = 1'b1; i_beat_ack = 1'b1;
    set_len(2, 4'd1);
    i_start[2] = 1'b1;
    for (int t = 1; t <= 20; t++) begin
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL b2b_vec t=%0d got %b want %b", t, dut_vec, exp_vec()); end
      if (o_done[2]) n_done++;
      if (o_request[2]) begin
        if (seen_hi && low_run > 0 && gap < 0) gap = low_run;
        seen_hi = 1; low_run = 0;
      end else if (seen_hi) low_run++;
    end
    i_start = '0;
    checks++;
    if (gap !== HOLDOFF_CYC + 1 || n_done !== 3) begin
      errors++; $display("FAIL b2b_gap gap=%0d done=%0d want gap=%0d done=3", gap, n_done, HOLDOFF_CYC + 1);
    end
    repeat (10) begin
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL b2b_drain got %b want %b", dut_vec, exp_vec()); end
    end
  endtask

  task automatic test_lost_grant();
    logic [1:10] sched;
    int done_at, n_done;
    sched = 10'b0110111100;
    done_at = 0; n_done = 0;
    arb_on = 1'b0; i_beat_ack = 1'b1;
    i_start[2] = 1'b1; set_len(2, 4'd4);
    for (int t = 1; t <= 10; t++) begin
      i_grant = '0;
      i_grant[2] = sched[t];
      tick();
      i_start = '0;
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL lost_vec t=%0d got %b want %b", t, dut_vec, exp_vec()); end
      if (o_done[2]) begin n_done++; if (done_at == 0) done_at = t; end
    end
    i_grant = '0;
    checks++;
    if (done_at !== 8 || n_done !== 1 || o_busy[2] !== 1'b0) begin
      errors++; $display("FAIL lost_done at=%0d n=%0d busy=%b want at=8 n=1 busy=0", done_at, n_done, o_busy[2]);
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 3000; t++) begin
      arb_on = (t < 1500);
      if (!arb_on) begin
        i_grant = '0;
        case ($urandom_range(0, 4))
          1: i_grant[1] = 1'b1;
          2: i_grant[2] = 1'b1;
          3: i_grant[3] = 1'b1;
          default: ;
        endcase
      end
      for (int k = 1; k <= 3; k++) begin
        i_start[k] = ($urandom_range(0, 5) == 0);
        set_len(k, LEN_W'($urandom_range(0, (1 << LEN_W) - 1)));
      end
      i_beat_ack = ($urandom_range(0, 3) != 0);
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL random_vec t=%0d got %b want %b", t, dut_vec, exp_vec()); end
    end
    i_start = '0;
  endtask

  initial begin
    Resetn = 1'b0; i_start = '0; i_len = '0; i_grant = '0; i_beat_ack = 1'b0; arb_on = 1'b0;
    model_reset();
    test_reset();
    test_single_burst();
    test_zero_len();
    test_timeout();
    test_contention();
    test_back_to_back();
    test_lost_grant();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
